sm_result_bcd_decoder: RTL
==========================

# sm_result_bcd_decoder

Sequential decoder for the calculator's 18-bit sign-magnitude result bus: bit 17 is the sign, bits 16:0 are the unsigned magnitude, as produced by the add/sub arithmetic units. It converts the magnitude to packed BCD with a shift-add-3 (double-dabble) state machine, one bit per clock. It exports the sign separately, and sits between the arithmetic result register and the 7-segment display driver.

## Interface
Parameters:
- MAG_W, 17, magnitude width; the input bus is MAG_W+1 bits.
- DIGITS, 6, number of BCD digits out; must satisfy 10^DIGITS > 2^MAG_W − 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- result_in  in  MAG_W+1  sign-magnitude value; [MAG_W] is the sign, [MAG_W-1:0] is the magnitude.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd_out and sign_out are valid from this cycle.
- sign_out  out  1  sign of the last converted value (1 = negative).
- bcd_out  out  4*DIGITS  packed BCD; digit 0 (units) is in [3:0].

## Operation
- Reset: while rst_n is low at a clock edge:
  - state ← IDLE; busy, done, sign_out ← 0; bcd_out ← 0; internal shift and BCD registers ← 0.
  - Reset during SHIFT aborts the conversion: no done pulse, outputs cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy = 0, done = 0.
  - On start = 1: capture magnitude into the shift register, capture sign, clear the BCD accumulator and bit counter, go to SHIFT.
- SHIFT:
  - busy = 1.
  - Each cycle, every BCD digit ≥ 5 gets +3 first. Then {accumulator, shift register} shifts left by 1, and the magnitude MSB enters accumulator bit 0.
  - The counter increments each cycle. On the MAG_W-th shift, the same edge loads bcd_out with the post-shift accumulator, loads sign_out, and moves to DONE.
- DONE:
  - done = 1, busy = 0 for exactly one cycle, then IDLE.
  - start is ignored in DONE.
- start while busy or in DONE: ignored, with no effect on the in-flight value; result_in is not resampled.
- Negative zero: if the captured sign = 1 and the magnitude = 0, sign_out ← 0. A zero result is always displayed as positive.
- Width rules:
  - Each digit's correction is a 4-bit add; with the ≥ 5 pre-check, no digit ever exceeds 9 after the shift.
  - The accumulator is 4*DIGITS bits; no overflow for legal parameters.
- bcd_out and sign_out hold their last value until the next done edge or reset. They never show intermediate accumulator values.

## Timing
- Capture edge E0: start = 1 in IDLE. busy = 1 from the cycle after E0.
- Shifts occur on edges E1 … E_MAG_W. After edge E_MAG_W: done = 1, busy = 0, outputs valid.
- Latency: done is high in the cycle following edge E0+MAG_W (17 edges for defaults).
- Throughput: one conversion per MAG_W+2 cycles. The earliest accepted start after a done pulse is the cycle after done.
- result_in only needs to be stable at edge E0.

## Test plan
- Reset then zero:
  - rst_n low 2 cycles → busy, done, sign_out, bcd_out all 0.
  - Then start with result_in = 18'h00000 → after 17 edges, done pulse, bcd_out = 24'h000000, sign_out = 0.
- Positive:
  - result_in = {1'b0, 17'd255} → bcd_out = 24'h000255, sign_out = 0.
  - done exactly 17 edges after capture, high for exactly 1 cycle.
- Negative and max:
  - {1'b1, 17'd127} → bcd_out = 24'h000127, sign_out = 1.
  - {1'b0, 17'd131071} → bcd_out = 24'h131071.
- Negative zero: {1'b1, 17'd0} → bcd_out = 24'h000000, sign_out = 0.
- Ignored start:
  - Convert 999; pulse start with result_in = {1'b1, 17'd5} on shift cycle 8 and again in the DONE cycle.
  - Required: single done, bcd_out = 24'h000999, sign_out = 0, returns to IDLE.
- Reset mid-operation and back-to-back:
  - Drop rst_n on shift cycle 10 → no done, all outputs 0.
  - Then two back-to-back conversions (65535, then 1) → 24'h065535, then 24'h000001; the second start is accepted the cycle after the first done.

Source files
------------

// File: rtl/sm_result_bcd_decoder.sv
// sm_result_bcd_decoder
//   Converts the calculator's sign-magnitude result bus into packed BCD for
//   the 7-segment display driver. The conversion is sequential: a
//   shift-add-3 (double-dabble) state machine handles one magnitude bit per
//   clock. The sign is exported separately. Negative zero is shown as
//   positive.
//
// Ports
//   clk        in   rising-edge system clock
//   rst_n      in   synchronous active-low reset
//   start      in   conversion request, honoured only in IDLE
//   result_in  in   [MAG_W] sign, [MAG_W-1:0] magnitude
//   busy       out  high while shifting
//   done       out  one-cycle pulse; sign_out/bcd_out valid from this cycle
//   sign_out   out  sign of last converted value (1 = negative)
//   bcd_out    out  packed BCD, digit 0 (units) in [3:0]
module sm_result_bcd_decoder #(
  parameter int MAG_W  = 17,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MAG_W:0]        result_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sign_out,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(MAG_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [MAG_W-1:0]     shift_reg;
  logic [BCD_W-1:0]     acc;
  logic [BCD_W-1:0]     acc_adj;
  logic [BCD_W-1:0]     acc_shifted;
  logic [CNT_W-1:0]     cnt;
  logic                 sign_cap;
  logic                 capture;
  logic                 last_shift;

  // Pre-shift correction: any digit >= 5 would become >= 10 after doubling,
  // so +3 now makes the shift carry it into the next digit.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign acc_adj     = add3_digits(acc);
  assign acc_shifted = {acc_adj[BCD_W-2:0], shift_reg[MAG_W-1]};
  assign last_shift  = (cnt == CNT_W'(MAG_W - 1));

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      sign_cap  <= 1'b0;
      sign_out  <= 1'b0;
      bcd_out   <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        shift_reg <= result_in[MAG_W-1:0];
        acc       <= '0;
        cnt       <= '0;
        // A zero magnitude is always shown as positive.
        sign_cap  <= result_in[MAG_W] & (|result_in[MAG_W-1:0]);
      end else if (state == SHIFT) begin
        shift_reg <= {shift_reg[MAG_W-2:0], 1'b0};
        acc       <= acc_shifted;
        cnt       <= cnt + CNT_W'(1);
        // Outputs only ever take the final accumulator value.
        if (last_shift) begin
          bcd_out  <= acc_shifted;
          sign_out <= sign_cap;
        end
      end
    end
  end

endmodule
